// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined signed ALU:
//   - class codes for ALU_FUN[3:2] (ARITH/LOGIC/CMP/SHIFT)
//   - op codes for ALU_FUN[1:0] within each class
//   - divider FSM state enum (S_IDLE/S_DIV/S_FIX)
//   - clog2 helper used to size the shift amount and the divider counter
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] ARITH   = 2'b00;
    localparam logic [1:0] LOGIC   = 2'b01;
    localparam logic [1:0] CMP     = 2'b10;
    localparam logic [1:0] SHIFT   = 2'b11;

    localparam logic [1:0] ADD     = 2'b00;
    localparam logic [1:0] SUB     = 2'b01;
    localparam logic [1:0] MUL     = 2'b10;
    localparam logic [1:0] DIV     = 2'b11;

    localparam logic [1:0] AND     = 2'b00;
    localparam logic [1:0] OR      = 2'b01;
    localparam logic [1:0] NAND    = 2'b10;
    localparam logic [1:0] NOR     = 2'b11;

    localparam logic [1:0] CMP_NOP = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_LT  = 2'b11;

    localparam logic [1:0] SLL     = 2'b00;
    localparam logic [1:0] SRL     = 2'b01;
    localparam logic [1:0] SRA     = 2'b10;
    localparam logic [1:0] ROL     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DIV  = 2'b01,
        S_FIX  = 2'b10
    } div_state_t;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_div.sv
// ---------------------------------------------------------------------------
// alu_seq_div
// Multi-cycle signed divider (restoring division on magnitudes).
// A start pulse in S_IDLE latches the operands; W iterations follow in S_DIV,
// then one S_FIX cycle applies signs and raises done for exactly one cycle.
// Quotient truncates toward zero, remainder takes the sign of a.
// Ports:
//   clk, rst          clock, synchronous active-high reset (aborts a division)
//   start, a, b       launch a division of a by b (honoured only when idle)
//   busy              high while a division is in flight (S_DIV or S_FIX)
//   done              high during S_FIX; quotient/remainder/divz/ovf valid
//   quotient          W-bit signed quotient (all ones on divide by zero)
//   remainder         W-bit signed remainder (a on divide by zero)
//   divz, ovf         divide-by-zero and most-negative/-1 overflow status
// ---------------------------------------------------------------------------
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         divz,
    output logic         ovf
);

    localparam int CW = clog2(W);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_t   state;
    logic [CW-1:0] count;
    logic [W-1:0] divisor_mag;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic [W-1:0] a_hold;
    logic         neg_q;
    logic         neg_r;
    logic         zero_div;
    logic         ovf_case;
    logic [W:0]   shifted;
    logic [W:0]   trial;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and try to subtract the divisor magnitude. A borrow
    // (trial[W]) means the subtraction is undone and the quotient bit is 0.
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, divisor_mag};
    end

    // FSM and datapath registers. The dividend magnitude is shifted out of
    // quo from the top while quotient bits are shifted in at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            divisor_mag <= '0;
            quo         <= '0;
            rem         <= '0;
            a_hold      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            ovf_case    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo         <= a[W-1] ? -a : a;
                        divisor_mag <= b[W-1] ? -b : b;
                        rem         <= '0;
                        a_hold      <= a;
                        neg_q       <= a[W-1] ^ b[W-1];
                        neg_r       <= a[W-1];
                        zero_div    <= (b == '0);
                        ovf_case    <= (a == MOST_NEG) && (b == '1);
                        count       <= CW'(W - 1);
                        state       <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
                    quo <= {quo[W-2:0], ~trial[W]};
                    if (count == '0) state <= S_FIX;
                    else             count <= count - 1'b1;
                end
                S_FIX: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sign fix-up and the two architecturally defined special cases, which
    // take priority over whatever the magnitude loop produced.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FIX);
        divz      = zero_div;
        ovf       = ovf_case;
        quotient  = neg_q ? -quo : quo;
        remainder = neg_r ? -rem : rem;
        if (zero_div) begin
            quotient  = '1;
            remainder = a_hold;
        end else if (ovf_case) begin
            quotient  = MOST_NEG;
            remainder = '0;
        end
    end

endmodule

// File: rtl/signed_alu_pipe.sv
// ---------------------------------------------------------------------------
// signed_alu_pipe
// Pipelined signed ALU with valid/ready handshaking and one output register.
// ALU_FUN[3:2] selects the class (arith/logic/compare/shift), [1:0] the op.
// Configuration macro: ALU_DIV_EN
//   defined   -> op 0011 is a W+1 cycle signed divide via alu_seq_div
//   undefined -> no divider; op 0011 completes in one cycle with ALU_OUT=0
//                and DIVZ_Flag=1 as an illegal-op indication
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   A, B                 signed operands (B also supplies the shift amount)
//   ALU_FUN, IN_TAG      opcode and sideband tag of the request
//   IN_VALID/IN_READY    request handshake
//   ALU_OUT              2W-bit registered result
//   Carry_OUT, OVF_Flag, DIVZ_Flag, Class_Flag   registered status
//   OUT_TAG              tag of the registered result
//   OUT_VALID/OUT_READY  result handshake
// ---------------------------------------------------------------------------
module signed_alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [3:0]              ALU_FUN,
    input  logic [TAG_WIDTH-1:0]    IN_TAG,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [2*DATA_WIDTH-1:0] ALU_OUT,
    output logic                    Carry_OUT,
    output logic                    OVF_Flag,
    output logic                    DIVZ_Flag,
    output logic [3:0]              Class_Flag,
    output logic [TAG_WIDTH-1:0]    OUT_TAG,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = clog2(W);

    logic            in_fire;
    logic            div_accept;
    logic [2*W-1:0]  res_d;
    logic            carry_d;
    logic            ovf_d;
    logic            divz_d;
    logic [3:0]      class_d;
    logic [W:0]      sum_x;
    logic [W:0]      dif_x;
    logic [2*W-1:0]  prod;
    logic [SW-1:0]   amt;
    logic [W-1:0]    sra_v;
    logic [2*W-1:0]  rot;

    assign in_fire = IN_VALID && IN_READY;

`ifdef ALU_DIV_EN
    logic                 div_busy;
    logic                 div_done;
    logic [W-1:0]         div_quo;
    logic [W-1:0]         div_rem;
    logic                 div_divz;
    logic                 div_ovf;
    logic [TAG_WIDTH-1:0] div_tag;

    assign div_accept = in_fire && (ALU_FUN == {ARITH, DIV});
    assign IN_READY   = !div_busy && (!OUT_VALID || OUT_READY);

    alu_seq_div #(.W(W)) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_accept),
        .a         (A),
        .b         (B),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem),
        .divz      (div_divz),
        .ovf       (div_ovf)
    );

    // The divide result leaves the datapath W+1 cycles after the request,
    // so its tag is parked here until the divider finishes.
    always_ff @(posedge CLK) begin
        if (RST)             div_tag <= '0;
        else if (div_accept) div_tag <= IN_TAG;
    end
`else
    assign div_accept = 1'b0;
    assign IN_READY   = !OUT_VALID || OUT_READY;
`endif

    // Single-cycle datapath. Add/sub use W+1-bit sign-extended operands so
    // the exact result is available; unsigned carry-out of the W-bit
    // operation is the majority of the MSB inputs and the MSB carry-in,
    // which reduces to the expressions below given the W-bit sum bit.
    always_comb begin
        sum_x   = {A[W-1], A} + {B[W-1], B};
        dif_x   = {A[W-1], A} - {B[W-1], B};
        prod    = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
        amt     = B[SW-1:0];
        sra_v   = $signed(A) >>> amt;
        rot     = {A, A} << amt;
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        divz_d  = 1'b0;
        class_d = 4'b0001 << ALU_FUN[3:2];
        case (ALU_FUN[3:2])
            ARITH: begin
                case (ALU_FUN[1:0])
                    ADD: begin
                        res_d   = {{(W-1){sum_x[W]}}, sum_x};
                        carry_d = (A[W-1] & B[W-1]) | ((A[W-1] ^ B[W-1]) & ~sum_x[W-1]);
                        ovf_d   = (A[W-1] == B[W-1]) && (sum_x[W-1] != A[W-1]);
                    end
                    SUB: begin
                        res_d   = {{(W-1){dif_x[W]}}, dif_x};
                        carry_d = (A[W-1] & ~B[W-1]) | ((A[W-1] ^ ~B[W-1]) & ~dif_x[W-1]);
                        ovf_d   = (A[W-1] != B[W-1]) && (dif_x[W-1] != A[W-1]);
                    end
                    MUL: res_d = prod;
                    default: begin
                        // Only reached without the divider: illegal-op marker.
                        res_d  = '0;
                        divz_d = 1'b1;
                    end
                endcase
            end
            LOGIC: begin
                case (ALU_FUN[1:0])
                    AND:     res_d = {{W{1'b0}}, A & B};
                    OR:      res_d = {{W{1'b0}}, A | B};
                    NAND:    res_d = {{W{1'b0}}, ~(A & B)};
                    default: res_d = {{W{1'b0}}, ~(A | B)};
                endcase
            end
            CMP: begin
                case (ALU_FUN[1:0])
                    CMP_EQ:  res_d = {{(2*W-1){1'b0}}, A == B};
                    CMP_GT:  res_d = {{(2*W-1){1'b0}}, $signed(A) > $signed(B)};
                    CMP_LT:  res_d = {{(2*W-1){1'b0}}, $signed(A) < $signed(B)};
                    default: res_d = '0;
                endcase
            end
            default: begin
                case (ALU_FUN[1:0])
                    SLL:     res_d = {{W{1'b0}}, A << amt};
                    SRL:     res_d = {{W{1'b0}}, A >> amt};
                    SRA:     res_d = {{W{1'b0}}, sra_v};
                    default: res_d = {{W{1'b0}}, rot[2*W-1:W]};
                endcase
            end
        endcase
    end

    // Output register. A finishing divide has priority (no request can be
    // accepted while the divider is busy anyway); otherwise a non-divide
    // request loads directly, and a drained result simply drops valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_OUT    <= '0;
            Carry_OUT  <= 1'b0;
            OVF_Flag   <= 1'b0;
            DIVZ_Flag  <= 1'b0;
            Class_Flag <= '0;
            OUT_TAG    <= '0;
            OUT_VALID  <= 1'b0;
        end
`ifdef ALU_DIV_EN
        else if (div_done) begin
            ALU_OUT    <= {div_rem, div_quo};
            Carry_OUT  <= 1'b0;
            OVF_Flag   <= div_ovf;
            DIVZ_Flag  <= div_divz;
            Class_Flag <= 4'b0001;
            OUT_TAG    <= div_tag;
            OUT_VALID  <= 1'b1;
        end
`endif
        else if (in_fire && !div_accept) begin
            ALU_OUT    <= res_d;
            Carry_OUT  <= carry_d;
            OVF_Flag   <= ovf_d;
            DIVZ_Flag  <= divz_d;
            Class_Flag <= class_d;
            OUT_TAG    <= IN_TAG;
            OUT_VALID  <= 1'b1;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_signed_alu_pipe
// Self-checking bench for signed_alu_pipe (DATA_WIDTH=16, TAG_WIDTH=4).
// A table of hand-computed single-cycle vectors is streamed back-to-back,
// followed by directed sequences for back-pressure, divide (or the
// illegal-op indication when ALU_DIV_EN is undefined) and reset.
// ---------------------------------------------------------------------------
module tb_signed_alu_pipe;

    localparam int W  = 16;
    localparam int TW = 4;

    logic            CLK;
    logic            RST;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [3:0]      ALU_FUN;
    logic [TW-1:0]   IN_TAG;
    logic            IN_VALID;
    logic            IN_READY;
    logic [2*W-1:0]  ALU_OUT;
    logic            Carry_OUT;
    logic            OVF_Flag;
    logic            DIVZ_Flag;
    logic [3:0]      Class_Flag;
    logic [TW-1:0]   OUT_TAG;
    logic            OUT_VALID;
    logic            OUT_READY;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  fun;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        logic        divz;
        logic [3:0]  cls;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    signed_alu_pipe #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .IN_TAG     (IN_TAG),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .ALU_OUT    (ALU_OUT),
        .Carry_OUT  (Carry_OUT),
        .OVF_Flag   (OVF_Flag),
        .DIVZ_Flag  (DIVZ_Flag),
        .Class_Flag (Class_Flag),
        .OUT_TAG    (OUT_TAG),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] fun, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] tag,
                                 input logic valid);
        ALU_FUN  = fun;
        A        = a;
        B        = b;
        IN_TAG   = tag;
        IN_VALID = valid;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string name, input logic [31:0] res,
                               input logic carry, input logic ovf, input logic divz,
                               input logic [3:0] cls, input logic [3:0] tag);
        checkOutput({name, " valid"}, 64'(OUT_VALID),  64'd1);
        checkOutput({name, " out"},   64'(ALU_OUT),    64'(res));
        checkOutput({name, " carry"}, 64'(Carry_OUT),  64'(carry));
        checkOutput({name, " ovf"},   64'(OVF_Flag),   64'(ovf));
        checkOutput({name, " divz"},  64'(DIVZ_Flag),  64'(divz));
        checkOutput({name, " class"}, 64'(Class_Flag), 64'(cls));
        checkOutput({name, " tag"},   64'(OUT_TAG),    64'(tag));
    endtask

    task automatic checkCleared(input string name);
        checkOutput({name, " valid"}, 64'(OUT_VALID),  64'd0);
        checkOutput({name, " out"},   64'(ALU_OUT),    64'd0);
        checkOutput({name, " carry"}, 64'(Carry_OUT),  64'd0);
        checkOutput({name, " ovf"},   64'(OVF_Flag),   64'd0);
        checkOutput({name, " divz"},  64'(DIVZ_Flag),  64'd0);
        checkOutput({name, " class"}, 64'(Class_Flag), 64'd0);
        checkOutput({name, " tag"},   64'(OUT_TAG),    64'd0);
        checkOutput({name, " ready"}, 64'(IN_READY),   64'd1);
    endtask

    task automatic waitEdge;
        @(posedge CLK);
        #1;
    endtask

`ifdef ALU_DIV_EN
    // Launch one divide and time it: OUT_VALID must appear exactly W+1
    // cycles after the accepting edge with IN_READY low the whole time.
    task automatic runDiv(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, input logic [31:0] res,
                          input logic ovf, input logic divz);
        int  n;
        logic ready_low;
        applyStimulus(4'b0011, a, b, tag, 1'b1);
        checkOutput({name, " ready before"}, 64'(IN_READY), 64'd1);
        waitEdge();
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        n = 1;
        ready_low = 1'b1;
        while (!OUT_VALID && n < 40) begin
            if (IN_READY) ready_low = 1'b0;
            waitEdge();
            n++;
        end
        checkOutput({name, " latency"}, 64'(n), 64'(W + 1));
        checkOutput({name, " ready low"}, 64'(ready_low), 64'd1);
        checkResult(name, res, 1'b0, ovf, divz, 4'b0001, tag);
        waitEdge();
        checkOutput({name, " drained"}, 64'(OUT_VALID), 64'd0);
    endtask
`endif

    initial begin
        vecs[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 4'h1, 32'h00008000, 1'b0, 1'b1, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0001, 16'h0003, 16'h0005, 4'h2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[2]  = '{4'b0000, 16'hFFFF, 16'h0001, 4'h3, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b0001};
        vecs[3]  = '{4'b0001, 16'h8000, 16'h0001, 4'h4, 32'hFFFF7FFF, 1'b1, 1'b1, 1'b0, 4'b0001};
        vecs[4]  = '{4'b0010, 16'hFED4, 16'h00C8, 4'h5, 32'hFFFF15A0, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[5]  = '{4'b1110, 16'h8000, 16'h0013, 4'h6, 32'h0000F000, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[6]  = '{4'b0100, 16'hF0F0, 16'h3C3C, 4'h7, 32'h00003030, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[7]  = '{4'b0101, 16'hF0F0, 16'h0F00, 4'h8, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[8]  = '{4'b0110, 16'hFFFF, 16'h00FF, 4'h9, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[9]  = '{4'b0111, 16'h0000, 16'h0001, 4'hA, 32'h0000FFFE, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[10] = '{4'b1001, 16'h1234, 16'h1234, 4'hB, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[11] = '{4'b1010, 16'h0003, 16'hFFFF, 4'hC, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[12] = '{4'b1011, 16'h0003, 16'hFFFF, 4'hD, 32'h00000000, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[13] = '{4'b1000, 16'h1234, 16'h1234, 4'hE, 32'h00000000, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[14] = '{4'b1100, 16'h0001, 16'h0004, 4'hF, 32'h00000010, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[15] = '{4'b1101, 16'h8000, 16'h000F, 4'h0, 32'h00000001, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[16] = '{4'b1111, 16'h8001, 16'h0011, 4'h1, 32'h00000003, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[17] = '{4'b1111, 16'h1234, 16'h0010, 4'h2, 32'h00001234, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[18] = '{4'b0010, 16'h0100, 16'h0100, 4'h3, 32'h00010000, 1'b0, 1'b0, 1'b0, 4'b0001};

        // Reset and check the cleared state.
        RST       = 1'b1;
        OUT_READY = 1'b1;
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        repeat (2) waitEdge();
        RST = 1'b0;
        checkCleared("reset");

        // Stream the table back-to-back: one result per cycle, tags in order.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1);
            checkOutput($sformatf("vec%0d ready", i), 64'(IN_READY), 64'd1);
            waitEdge();
            checkResult($sformatf("vec%0d", i), vecs[i].res, vecs[i].carry,
                        vecs[i].ovf, vecs[i].divz, vecs[i].cls, vecs[i].tag);
        end
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        waitEdge();
        checkOutput("stream drained", 64'(OUT_VALID), 64'd0);

        // Back-pressure: held result must stay put and block new requests.
        OUT_READY = 1'b0;
        applyStimulus(4'b0000, 16'h0010, 16'h0020, 4'h5, 1'b1);
        waitEdge();
        applyStimulus(4'b0001, 16'h0010, 16'h0001, 4'h6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("stall%0d ready", k), 64'(IN_READY), 64'd0);
            checkOutput($sformatf("stall%0d valid", k), 64'(OUT_VALID), 64'd1);
            checkOutput($sformatf("stall%0d out", k), 64'(ALU_OUT), 64'h30);
            checkOutput($sformatf("stall%0d tag", k), 64'(OUT_TAG), 64'h5);
            waitEdge();
        end
        OUT_READY = 1'b1;
        #1;
        checkOutput("stall release ready", 64'(IN_READY), 64'd1);
        waitEdge();
        checkResult("stall next", 32'h0000000F, 1'b1, 1'b0, 1'b0, 4'b0001, 4'h6);
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        waitEdge();
        checkOutput("stall drained", 64'(OUT_VALID), 64'd0);

`ifdef ALU_DIV_EN
        runDiv("div -7/2", 16'hFFF9, 16'h0002, 4'h7, 32'hFFFFFFFD, 1'b0, 1'b0);
        runDiv("div 5/0", 16'h0005, 16'h0000, 4'h8, 32'h0005FFFF, 1'b0, 1'b1);
        runDiv("div min/-1", 16'h8000, 16'hFFFF, 4'h9, 32'h00008000, 1'b1, 1'b0);
        runDiv("div 100/-7", 16'h0064, 16'hFFF9, 4'hA, 32'h0002FFF2, 1'b0, 1'b0);

        // Reset five cycles into a divide: aborted, no result ever appears.
        applyStimulus(4'b0011, 16'h0064, 16'h0003, 4'hB, 1'b1);
        waitEdge();
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        repeat (4) waitEdge();
        RST = 1'b1;
        waitEdge();
        checkCleared("div abort");
        RST = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (W + 4) begin
                waitEdge();
                if (OUT_VALID) seen = 1'b1;
            end
            checkOutput("div abort no result", 64'(seen), 64'd0);
        end
`else
        // Without the divider, 0011 is a one-cycle illegal-op indication.
        applyStimulus(4'b0011, 16'h0005, 16'h0000, 4'h7, 1'b1);
        waitEdge();
        checkResult("illegal div", 32'h00000000, 1'b0, 1'b0, 1'b1, 4'b0001, 4'h7);
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);

        // Reset while a result is being held must clear it.
        OUT_READY = 1'b0;
        RST = 1'b1;
        waitEdge();
        checkCleared("held reset");
        RST = 1'b0;
        OUT_READY = 1'b1;
`endif

        applyStimulus(4'b1010, 16'h0003, 16'hFFFF, 4'h2, 1'b1);
        waitEdge();
        checkResult("post reset cmp", 32'h00000001, 1'b0, 1'b0, 1'b0, 4'b0100, 4'h2);
        applyStimulus(4'b0000, 16'h0, 16'h0, 4'h0, 1'b0);
        waitEdge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
